// File: rtl/wave_pkg.sv
// Shared types for the multi-mode wave generator: waveform mode, ramp direction
// and the mode the generator comes out of reset in.
package wave_pkg;

  typedef enum logic [1:0] {
    TRIANGLE = 2'd0,
    SAW_UP   = 2'd1,
    SAW_DOWN = 2'd2,
    SQUARE   = 2'd3
  } mode_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam mode_t WAVE_RESET_MODE = TRIANGLE;

endpackage

// File: rtl/wave_generator_bounded_stepper.sv
// Combinational helper: one clamped step up (to hi) and one clamped step down
// (to lo) from the current value, computed in N+1 bits so nothing wraps silently.
module bounded_stepper #(
  parameter int N = 8
) (
  input  logic [N-1:0] cur_i,
  input  logic [N-1:0] step_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  output logic [N-1:0] up_o,
  output logic [N-1:0] dn_o,
  output logic         hit_hi_o,
  output logic         hit_lo_o
);

  logic [N:0] sum;
  logic [N:0] diff;

  assign sum  = {1'b0, cur_i} + {1'b0, step_i};
  assign diff = {1'b0, cur_i} - {1'b0, step_i};

  // A borrow shows up as diff[N]; treat it like any other undershoot of lo.
  assign up_o     = (sum >= {1'b0, hi_i}) ? hi_i : sum[N-1:0];
  assign dn_o     = (diff[N] || (diff < {1'b0, lo_i})) ? lo_i : diff[N-1:0];
  assign hit_hi_o = (up_o == hi_i);
  assign hit_lo_o = (dn_o == lo_i);

endmodule

// File: rtl/wave_generator.sv
// Multi-mode wave generator (triangle, saw up/down, square) between lo..hi.
// Define WAVE_GENERATOR_SYNC_EN to add the sync input that forces a restart.
module wave_generator
  import wave_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
`ifdef WAVE_GENERATOR_SYNC_EN
  input  logic         sync,
`endif
  input  mode_t        mode,
  input  logic [N-1:0] step,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  output logic [N-1:0] out,
  output dir_t         dir,
  output logic         wrap
);

  logic [N-1:0] out_q, out_d;
  dir_t         dir_q, dir_d;
  logic         wrap_q, wrap_d;
  mode_t        mode_q, mode_d;
  logic [N-1:0] cnt_q, cnt_d;

  logic [N-1:0] step_eff;
  logic [N-1:0] up_val, dn_val;
  logic         hit_hi, hit_lo;
  logic         sync_w;
  logic         restart;

`ifdef WAVE_GENERATOR_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  assign step_eff = (step == '0) ? {{(N-1){1'b0}}, 1'b1} : step;
  assign restart  = sync_w || (ena && ((lo >= hi) || (mode != mode_q)));

  bounded_stepper #(.N(N)) u_stepper (
    .cur_i    (out_q),
    .step_i   (step_eff),
    .lo_i     (lo),
    .hi_i     (hi),
    .up_o     (up_val),
    .dn_o     (dn_val),
    .hit_hi_o (hit_hi),
    .hit_lo_o (hit_lo)
  );

  always_comb begin
    // NOTE: every _d gets a hold default first, so no path can infer a latch.
    out_d  = out_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (restart) begin
      out_d  = lo;
      dir_d  = UP;
      cnt_d  = '0;
      mode_d = mode;
    end else if (ena) begin
      if ((out_q < lo) || (out_q > hi)) begin
        out_d = lo;
        dir_d = UP;
      end else begin
        unique case (mode_q)
          TRIANGLE: begin
            if (dir_q == UP) begin
              out_d = up_val;
              if (hit_hi) dir_d = DOWN;
            end else begin
              out_d = dn_val;
              if (hit_lo) begin
                dir_d  = UP;
                wrap_d = 1'b1;
              end
            end
          end
          SAW_UP: begin
            dir_d = UP;
            if (out_q == hi) begin
              out_d  = lo;
              wrap_d = 1'b1;
            end else begin
              out_d = up_val;
            end
          end
          SAW_DOWN: begin
            dir_d = DOWN;
            if (out_q == lo) begin
              out_d  = hi;
              wrap_d = 1'b1;
            end else begin
              out_d = dn_val;
            end
          end
          SQUARE: begin
            // Phase counter runs 0..step_eff-1 and flips the level on its last value.
            if (cnt_q == step_eff - 1'b1) begin
              cnt_d = '0;
              dir_d = (dir_q == UP) ? DOWN : UP;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
            out_d  = (dir_d == DOWN) ? hi : lo;
            wrap_d = (dir_q == UP) && (dir_d == DOWN);
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      dir_q  <= UP;
      wrap_q <= 1'b0;
      mode_q <= WAVE_RESET_MODE;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out  = out_q;
  assign dir  = dir_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_wave_generator.sv
// Self-checking bench for wave_generator: a behavioural model feeds a scoreboard
// queue each driven cycle; directed sequences are also checked against fixed tables.
module tb_wave_generator;
  import wave_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic         sync_s = 1'b0;
  mode_t        mode = TRIANGLE;
  logic [N-1:0] step = 8'd1;
  logic [N-1:0] lo = 8'd0;
  logic [N-1:0] hi = 8'd255;
  logic [N-1:0] out;
  dir_t         dir;
  logic         wrap;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [N-1:0] e_out;
    logic         e_dir;
    logic         e_wrap;
  } exp_t;
  exp_t sb_q[$];

  int    m_out = 0;
  int    m_dir = 0;
  int    m_cnt = 0;
  mode_t m_mode = TRIANGLE;

  always #5 clk = ~clk;

  wave_generator #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
`ifdef WAVE_GENERATOR_SYNC_EN
    .sync (sync_s),
`endif
    .mode (mode),
    .step (step),
    .lo   (lo),
    .hi   (hi),
    .out  (out),
    .dir  (dir),
    .wrap (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference, evaluated on the inputs about to be sampled.
  task automatic model_update();
    int s, l, h, n, nd, wr;
    exp_t e;
    s  = (step == 0) ? 1 : int'(step);
    l  = int'(lo);
    h  = int'(hi);
    wr = 0;
    if (rst) begin
      m_out = 0; m_dir = 0; m_cnt = 0; m_mode = TRIANGLE;
    end else if (sync_s || (ena && (l >= h || mode != m_mode))) begin
      m_out = l; m_dir = 0; m_cnt = 0; m_mode = mode;
    end else if (ena) begin
      if (m_out < l || m_out > h) begin
        m_out = l; m_dir = 0;
      end else begin
        case (m_mode)
          TRIANGLE: begin
            if (m_dir == 0) begin
              n = m_out + s;
              if (n >= h) begin n = h; m_dir = 1; end
            end else begin
              n = m_out - s;
              if (n <= l) begin n = l; m_dir = 0; wr = 1; end
            end
            m_out = n;
          end
          SAW_UP: begin
            m_dir = 0;
            if (m_out == h) begin m_out = l; wr = 1; end
            else m_out = (m_out + s > h) ? h : m_out + s;
          end
          SAW_DOWN: begin
            m_dir = 1;
            if (m_out == l) begin m_out = h; wr = 1; end
            else m_out = (m_out - s < l) ? l : m_out - s;
          end
          default: begin
            nd = m_dir;
            if (m_cnt == s - 1) begin m_cnt = 0; nd = 1 - m_dir; end
            else m_cnt = (m_cnt + 1) % 256;
            wr    = (nd == 1 && m_dir == 0) ? 1 : 0;
            m_out = (nd == 1) ? h : l;
            m_dir = nd;
          end
        endcase
      end
    end
    e.e_out  = m_out[N-1:0];
    e.e_dir  = m_dir[0];
    e.e_wrap = wr[0];
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    int   depth;
    model_update();
    @(posedge clk);
    #1;
    depth = sb_q.size();
    check("sb_depth", depth, 1);
    if (depth > 0) begin
      e = sb_q.pop_front();
      check("out", out, e.e_out);
      check("dir", dir, e.e_dir);
      check("wrap", wrap, e.e_wrap);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t2[8]    = '{10, 14, 18, 20, 16, 12, 10, 14};
    int t2w[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};
    int t3u[5]   = '{3, 6, 9, 0, 3};
    int t3uw[5]  = '{0, 0, 0, 1, 0};
    int t3d[6]   = '{0, 9, 6, 3, 0, 9};
    int t3dw[6]  = '{0, 1, 0, 0, 0, 1};
    int t4[10]   = '{5, 5, 5, 200, 200, 200, 5, 5, 5, 200};
    int t4z[6]   = '{5, 200, 5, 200, 5, 200};
    int t5[4]    = '{55, 60, 55, 50};
    int t5w[4]   = '{0, 0, 0, 1};

    // Reset
    rst = 1'b1; ena = 1'b1;
    tick(); tick();
    check("rst_out", out, 0);
    check("rst_dir", dir, UP);
    check("rst_wrap", wrap, 0);

    // 1: full-range triangle, step 1
    rst = 1'b0; mode = TRIANGLE; lo = 8'd0; hi = 8'd255; step = 8'd1;
    for (int i = 0; i < 511; i++) begin
      tick();
      check("t1_out", out, (i < 255) ? i + 1 : ((i < 510) ? 509 - i : 1));
      check("t1_wrap", wrap, (i == 509) ? 1 : 0);
    end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold", out, 1);
    end

    // 2: out-of-range fixup from reset, then triangle 10..20 step 4
    rst = 1'b1; tick(); rst = 1'b0;
    ena = 1'b1; lo = 8'd10; hi = 8'd20; step = 8'd4;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_out", out, t2[i]);
      check("t2_wrap", wrap, t2w[i]);
    end

    // 3: saw up, then saw down
    mode = SAW_UP; lo = 8'd0; hi = 8'd9; step = 8'd3;
    tick();
    check("t3_restart", out, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3u_out", out, t3u[i]);
      check("t3u_wrap", wrap, t3uw[i]);
    end
    mode = SAW_DOWN;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3d_out", out, t3d[i]);
      check("t3d_wrap", wrap, t3dw[i]);
    end

    // 4: square, half-period 3, then step 0 (toggle every cycle)
    mode = SQUARE; lo = 8'd5; hi = 8'd200; step = 8'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_out", out, t4[i]);
      check("t4_wrap", wrap, (i == 3 || i == 9) ? 1 : 0);
    end
    step = 8'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t4z_out", out, t4z[i]);
      check("t4z_wrap", wrap, (i % 2 == 1) ? 1 : 0);
    end

    // 5: collapse bounds mid-ramp, then restore
    mode = TRIANGLE; lo = 8'd0; hi = 8'd100; step = 8'd7;
    for (int i = 0; i < 5; i++) tick();
    check("t5_ramp", out, 28);
    lo = 8'd50; hi = 8'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_bad_out", out, 50);
      check("t5_bad_dir", dir, UP);
      check("t5_bad_wrap", wrap, 0);
    end
    hi = 8'd60; step = 8'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_out", out, t5[i]);
      check("t5_wrap", wrap, t5w[i]);
    end

    // 6: reset mid-period with ena high
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_rst_out", out, 0);
    check("t6_rst_dir", dir, UP);
    check("t6_rst_wrap", wrap, 0);
    rst = 1'b0;

`ifdef WAVE_GENERATOR_SYNC_EN
    mode = SAW_UP; lo = 8'd2; hi = 8'd11; step = 8'd3;
    for (int i = 0; i < 3; i++) tick();
    ena = 1'b0; sync_s = 1'b1;
    tick();
    check("sync_idle_out", out, 2);
    sync_s = 1'b0; ena = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("sync_at_hi", out, 11);
    sync_s = 1'b1;
    tick();
    check("sync_wrap_out", out, 2);
    check("sync_wrap_wrap", wrap, 0);
    sync_s = 1'b0;
`endif

    // Random mix of modes, bounds, steps and gating against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ena = ($urandom_range(0, 9) != 0);
`ifdef WAVE_GENERATOR_SYNC_EN
      sync_s = ($urandom_range(0, 49) == 0);
`endif
      if ($urandom_range(0, 19) == 0) mode = mode_t'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        lo = 8'($urandom_range(0, 120));
        hi = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 14) == 0) step = 8'($urandom_range(0, 40));
      tick();
    end
    rst = 1'b0; sync_s = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_generator.md
Name: wave_generator

Overview:
- Parametrised multi-mode successor to the counter-based triangle source.
- Produces an N-bit triangle, rising sawtooth, falling sawtooth or square wave between programmable bounds lo..hi, with programmable step and enable gating.
- Feeds PWM/DAC test paths; the registered `wrap` pulse marks period boundaries for downstream sync.

Parameters:
- N, 8, output and bound width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  advance one step this cycle; all state holds when low.
- mode  in  2  wave_pkg::mode_t: TRIANGLE=0, SAW_UP=1, SAW_DOWN=2, SQUARE=3.
- step  in  N  increment per enabled cycle (ramp modes); half-period in enabled cycles (SQUARE); 0 is treated as 1.
- lo  in  N  lower bound, unsigned.
- hi  in  N  upper bound, unsigned.
- out  out  N  registered waveform value.
- dir  out  1  wave_pkg::dir_t: UP=0, DOWN=1; current ramp direction, or square level (1=hi).
- wrap  out  1  registered one-cycle period-boundary pulse.

Behaviour:
- Reset (rst=1 at posedge): out=0, dir=UP, wrap=0, internal mode_q=TRIANGLE, square phase count=0. rst has priority over everything.
- ena=0: out, dir, mode_q and phase count hold; wrap=0.
- All inputs are sampled on enabled cycles only. Latency is 1 cycle from an enabled posedge to the new out.
- Arithmetic is done in N+1 bits, so there is no silent overflow. Up-steps clamp at hi; down-steps clamp at lo.
- Enabled-cycle priority, highest first:
  1. Bad config (lo >= hi): out<=lo, dir<=UP, count<=0, wrap=0, mode_q<=mode.
  2. Mode change (mode != mode_q): restart with out<=lo, dir<=UP, count<=0, wrap=0; mode_q<=mode.
  3. Out of range (out<lo or out>hi, e.g. after a bound change or reset with lo>0): out<=lo, dir<=UP, wrap=0.
  4. Normal step, per mode below.
- TRIANGLE:
  - UP: nxt=min(out+step,hi); if nxt==hi then dir<=DOWN.
  - DOWN: nxt=max(out-step,lo); if nxt==lo then dir<=UP and wrap=1.
  - With lo=0, hi=2^N-1, step=1 the sequence is 0,1..2^N-1,2^N-2..0,1 (period 2*(2^N-1)).
- SAW_UP:
  - If out==hi: out<=lo, wrap=1.
  - Otherwise out<=min(out+step,hi).
  - dir stays UP.
- SAW_DOWN:
  - On first entry, out=lo from the mode-change restart, so the first step wraps to hi.
  - If out==lo: out<=hi, wrap=1.
  - Otherwise out<=max(out-step,lo).
  - dir stays DOWN.
- SQUARE:
  - count increments each enabled cycle.
  - When count==max(step,1)-1: count<=0 and dir toggles.
  - out<=(dir_next ? hi : lo).
  - wrap=1 on a lo-to-hi transition.
- Changes to step/lo/hi take effect on the next enabled cycle without a restart, except for the out-of-range rule.
- Simultaneous wrap with a mode change or bad config: the restart wins and wrap=0.

Optional Feature:
- Macro: WAVE_GENERATOR_SYNC_EN.
- Defined:
  - Adds input port `sync` (1 bit, after ena).
  - sync=1 at a posedge (regardless of ena) forces out<=lo, dir<=UP, count<=0, wrap<=0, mode_q<=mode.
  - Priority: below rst, above all other rules.
- Undefined: no sync port and no such behaviour; the module is otherwise identical.

Decomposition:
- Package wave_pkg contains:
  - typedef enum logic [1:0] mode_t {TRIANGLE, SAW_UP, SAW_DOWN, SQUARE};
  - typedef enum logic dir_t {UP, DOWN};
  - localparam mode_t WAVE_RESET_MODE = TRIANGLE.
- Sub-module bounded_stepper (combinational): computes clamped out±step in N+1 bits and flags hit_hi/hit_lo.
- wave_generator holds all registers, the mode FSM and the square phase counter.

Test Plan:
1. Reset, then ena=1, TRIANGLE, lo=0, hi=255, step=1:
   - out = 1,2..255,254..0,1.
   - wrap high only on the cycle out becomes 0.
   - ena=0 for 5 cycles holds the value.
2. TRIANGLE, lo=10, hi=20, step=4, starting from reset out=0:
   - out = 10 (out-of-range fixup), 14, 18, 20 (dir=DOWN), 16, 12, 10 (wrap=1), 14.
3. SAW_UP, lo=0, hi=9, step=3:
   - out = 3,6,9,0 (wrap=1),3.
   - Then switch to SAW_DOWN: out = 0 (restart), 9 (wrap=1), 6, 3, 0, 9.
4. SQUARE, lo=5, hi=200, step=3:
   - out holds 5 for 3 enabled cycles, then 200 for 3 (wrap=1 on the first 200 cycle), repeating.
   - step=0 toggles every cycle.
5. Set lo=50, hi=50 mid-ramp:
   - out=50, dir=UP, wrap=0 held every enabled cycle.
   - Restoring hi=60 with step=5 gives 55, 60, 55, 50 (wrap=1).
6. Mid-period rst=1 with ena=1 gives out=0, dir=UP, wrap=0 next cycle.
   - With WAVE_GENERATOR_SYNC_EN: sync=1 while ena=0 gives out=lo next cycle, and it overrides a coincident wrap.
